// File: rtl/io_bus_arbiter_if.sv
// io_bus_arbiter_if: CPU, aux master and io-block signals shared by the arbiter and its environment
interface io_bus_arbiter_if #(parameter int CNT_W = 16);
  logic             cpu_access;
  logic             cpu_we;
  logic [31:0]      cpu_a;
  logic [31:0]      cpu_wd;
  logic [2:0]       cpu_funct3;
  logic [31:0]      cpu_rd;
  logic             aux_valid;
  logic             aux_ready;
  logic             aux_we;
  logic [31:0]      aux_a;
  logic [31:0]      aux_wd;
  logic [2:0]       aux_funct3;
  logic             aux_rvalid;
  logic [31:0]      aux_rdata;
  logic             io_we;
  logic [31:0]      io_a;
  logic [31:0]      io_wd;
  logic [2:0]       io_funct3;
  logic [31:0]      io_rd;
  logic             starved;
  logic [CNT_W-1:0] contention_cnt;
  modport slave (
    input  cpu_access, cpu_we, cpu_a, cpu_wd, cpu_funct3,
    input  aux_valid, aux_we, aux_a, aux_wd, aux_funct3, io_rd,
    output cpu_rd, aux_ready, aux_rvalid, aux_rdata,
    output io_we, io_a, io_wd, io_funct3, starved, contention_cnt
  );
  modport master (
    output cpu_access, cpu_we, cpu_a, cpu_wd, cpu_funct3,
    output aux_valid, aux_we, aux_a, aux_wd, aux_funct3, io_rd,
    input  cpu_rd, aux_ready, aux_rvalid, aux_rdata,
    input  io_we, io_a, io_wd, io_funct3, starved, contention_cnt
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the io register port between the CPU (absolute priority) and one aux master
module io_bus_arbiter #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input logic             clk,
  input logic             reset_n,
  io_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PEND, RESP} state_t;
  localparam int WW = $clog2(MAX_WAIT + 1);
  state_t           state;
  logic             a_we;
  logic [31:0]      a_a;
  logic [31:0]      a_wd;
  logic [2:0]       a_f3;
  logic [WW-1:0]    wait_cnt;
  logic [CNT_W-1:0] cont;
  logic [31:0]      rdata;
  logic             grant;
  assign grant = state == PEND && !bus.cpu_access;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      a_we     <= 1'b0;
      a_a      <= '0;
      a_wd     <= '0;
      a_f3     <= '0;
      wait_cnt <= '0;
      cont     <= '0;
      rdata    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.aux_valid) begin
          a_we  <= bus.aux_we;
          a_a   <= bus.aux_a;
          a_wd  <= bus.aux_wd;
          a_f3  <= bus.aux_funct3;
          state <= PEND;
        end
        PEND: if (bus.cpu_access) begin
          wait_cnt <= wait_cnt == WW'(MAX_WAIT) ? wait_cnt : wait_cnt + 1'b1;
          cont     <= &cont ? cont : cont + 1'b1;
        end else begin
          rdata    <= a_we ? '0 : bus.io_rd;
          wait_cnt <= '0;
          state    <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // CPU traffic passes straight through; aux only borrows the port in its grant cycle
  always_comb begin
    bus.io_we     = bus.cpu_access ? bus.cpu_we : grant ? a_we : 1'b0;
    bus.io_a      = grant ? a_a : bus.cpu_a;
    bus.io_wd     = grant ? a_wd : bus.cpu_wd;
    bus.io_funct3 = grant ? a_f3 : bus.cpu_funct3;
  end
  assign bus.cpu_rd         = bus.io_rd;
  assign bus.aux_ready      = state == IDLE;
  assign bus.aux_rvalid     = state == RESP;
  assign bus.aux_rdata      = rdata;
  assign bus.starved        = state == PEND && wait_cnt >= WW'(MAX_WAIT);
  assign bus.contention_cnt = cont;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: randomized and directed checks of io_bus_arbiter against a transaction-level model
module tb_io_bus_arbiter;
  localparam int MW = 16;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  io_bus_arbiter_if #(.CNT_W(CW)) bus();
  io_bus_arbiter #(.MAX_WAIT(MW), .CNT_W(CW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [31:0] switches = 32'h0;
  logic [31:0] leds = 32'h0;
  // io block stand-in: switches at 0x1000, led register at 0x1004, pattern elsewhere
  function automatic logic [31:0] env_rd(input logic [31:0] a);
    return a == 32'h1000 ? switches : a == 32'h1004 ? leds : a ^ 32'h5A5A_0000;
  endfunction
  assign bus.io_rd = bus.io_a == 32'h1000 ? switches : bus.io_a == 32'h1004 ? leds : bus.io_a ^ 32'h5A5A_0000;
  always @(posedge clk) if (bus.io_we && bus.io_a == 32'h1004) leds <= bus.io_wd;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask
  // transaction model: one outstanding aux request, its response owed next cycle, and wait tallies
  bit          m_pend, m_resp;
  logic        m_we;
  logic [31:0] m_a, m_wd, m_rdata, e_a;
  logic [2:0]  m_f3;
  int          m_wait, m_cont;
  bit          g;
  always @(negedge clk) begin
    if (!reset_n) begin
      m_pend = 0; m_resp = 0; m_wait = 0; m_cont = 0; m_rdata = 0;
    end
    g = m_pend && !bus.cpu_access;
    e_a = g ? m_a : bus.cpu_a;
    chk("aux_ready", 32'(bus.aux_ready), 32'(!m_pend && !m_resp));
    chk("aux_rvalid", 32'(bus.aux_rvalid), 32'(m_resp));
    chk("aux_rdata", bus.aux_rdata, m_rdata);
    chk("io_we", 32'(bus.io_we), 32'(bus.cpu_access ? bus.cpu_we : g ? m_we : 1'b0));
    chk("io_a", bus.io_a, e_a);
    chk("io_wd", bus.io_wd, g ? m_wd : bus.cpu_wd);
    chk("io_funct3", 32'(bus.io_funct3), 32'(g ? m_f3 : bus.cpu_funct3));
    chk("cpu_rd", bus.cpu_rd, env_rd(e_a));
    chk("starved", 32'(bus.starved), 32'(m_pend && m_wait >= MW));
    chk("contention_cnt", 32'(bus.contention_cnt), 32'(m_cont));
    if (reset_n) begin
      if (m_resp) m_resp = 0;
      else if (m_pend && bus.cpu_access) begin
        m_wait++;
        m_cont = m_cont + 1 > (1 << CW) - 1 ? (1 << CW) - 1 : m_cont + 1;
      end else if (m_pend) begin
        m_rdata = m_we ? 32'h0 : env_rd(m_a);
        m_pend = 0; m_resp = 1; m_wait = 0;
      end else if (bus.aux_valid) begin
        m_we = bus.aux_we; m_a = bus.aux_a; m_wd = bus.aux_wd; m_f3 = bus.aux_funct3;
        m_pend = 1;
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask
  function automatic logic [31:0] pick_a();
    int r = $urandom_range(0, 2);
    return r == 0 ? 32'h1000 : r == 1 ? 32'h1004 : $urandom;
  endfunction
  initial begin
    bus.cpu_access = 0; bus.cpu_we = 0; bus.cpu_a = 32'h2000; bus.cpu_wd = 0; bus.cpu_funct3 = 0;
    bus.aux_valid = 0; bus.aux_we = 0; bus.aux_a = 0; bus.aux_wd = 0; bus.aux_funct3 = 0;
    step();
    do_reset();
    // aux write with an idle CPU
    bus.aux_valid = 1; bus.aux_we = 1; bus.aux_a = 32'h1004; bus.aux_wd = 32'h5; bus.aux_funct3 = 3'd2;
    #1 chk("t1_ready", 32'(bus.aux_ready), 32'h1);
    step();
    bus.aux_valid = 0;
    #1 chk("t1_io_we", 32'(bus.io_we), 32'h1);
    chk("t1_io_a", bus.io_a, 32'h1004);
    chk("t1_io_wd", bus.io_wd, 32'h5);
    step();
    #1 chk("t1_rvalid", 32'(bus.aux_rvalid), 32'h1);
    chk("t1_rdata", bus.aux_rdata, 32'h0);
    chk("t1_leds", leds, 32'h5);
    step();
    // aux read blocked by three CPU cycles
    do_reset();
    switches = 32'hA;
    bus.aux_valid = 1; bus.aux_we = 0; bus.aux_a = 32'h1000;
    step();
    bus.aux_valid = 0; bus.cpu_access = 1; bus.cpu_we = 1; bus.cpu_a = 32'h2000; bus.cpu_wd = 32'h33;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t2_cpu_we", 32'(bus.io_we), 32'h1);
      chk("t2_cpu_a", bus.io_a, 32'h2000);
      step();
    end
    bus.cpu_access = 0;
    #1 chk("t2_grant_a", bus.io_a, 32'h1000);
    chk("t2_grant_we", 32'(bus.io_we), 32'h0);
    step();
    #1 chk("t2_rvalid", 32'(bus.aux_rvalid), 32'h1);
    chk("t2_rdata", bus.aux_rdata, 32'hA);
    chk("t2_cont", 32'(bus.contention_cnt), 32'h3);
    step();
    // long starvation, contention saturation
    do_reset();
    bus.aux_valid = 1; bus.aux_we = 0; bus.aux_a = 32'h1004;
    step();
    bus.aux_valid = 0; bus.cpu_access = 1;
    for (int k = 1; k <= 20; k++) begin
      bus.cpu_we = 1'($urandom); bus.cpu_a = 32'h3000 + 32'(k);
      #1 if (k == 1) chk("t3_not_starved", 32'(bus.starved), 32'h0);
      if (k == 17) chk("t3_starved", 32'(bus.starved), 32'h1);
      step();
    end
    bus.cpu_access = 0;
    #1 chk("t3_grant_starved", 32'(bus.starved), 32'h1);
    chk("t6_cont_sat", 32'(bus.contention_cnt), 32'hF);
    step();
    #1 chk("t3_starved_drop", 32'(bus.starved), 32'h0);
    chk("t3_rdata", bus.aux_rdata, 32'h5);
    step();
    // reset while pending drops the request
    bus.aux_valid = 1; bus.aux_we = 1; bus.aux_a = 32'h1004; bus.aux_wd = 32'h77;
    step();
    bus.aux_valid = 0; bus.cpu_access = 1; bus.cpu_we = 0;
    #1 reset_n = 0;
    #1 chk("t4_ready_rst", 32'(bus.aux_ready), 32'h1);
    chk("t4_io_we_rst", 32'(bus.io_we), 32'h0);
    step();
    bus.cpu_access = 0;
    #1 chk("t4_io_we_idle", 32'(bus.io_we), 32'h0);
    step();
    reset_n = 1;
    #1 chk("t4_ready_rel", 32'(bus.aux_ready), 32'h1);
    step();
    #1 chk("t4_no_rvalid", 32'(bus.aux_rvalid), 32'h0);
    chk("t4_leds", leds, 32'h5);
    // back-to-back requests with aux_valid held
    bus.aux_valid = 1; bus.aux_we = 0; bus.aux_a = 32'h1000;
    for (int i = 0; i < 6; i++) begin
      #1 chk("t5_ready", 32'(bus.aux_ready), 32'(i % 3 == 0));
      step();
    end
    bus.aux_valid = 0;
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.cpu_access = $urandom_range(0, 99) < 40;
      bus.cpu_we = 1'($urandom); bus.cpu_a = pick_a(); bus.cpu_wd = $urandom; bus.cpu_funct3 = 3'($urandom);
      bus.aux_valid = 1'($urandom); bus.aux_we = 1'($urandom); bus.aux_a = pick_a();
      bus.aux_wd = $urandom; bus.aux_funct3 = 3'($urandom);
      if ($urandom_range(0, 15) == 0) switches = $urandom;
      reset_n = $urandom_range(0, 499) != 0;
      step();
    end
    reset_n = 1;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
